multi_input_gather: RTL and testbench

MULTI_INPUT_GATHER -- requirements
Module: multi_input_gather

---
 rtl/multi_input_pkg.sv | 12 +
 rtl/multi_input_gather.sv | 175 +++++++++++++++++
 tb/tb_multi_input_gather.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_input_pkg.sv
// Shared types and parameter defaults for the gather / multi-input adder pair.
package multi_input_pkg;

    localparam int NUM_INPUT_DEF = 7;
    localparam int WIDTH_IN_DEF  = 16;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } gather_state_e;

endpackage

// File: rtl/multi_input_gather.sv
// Serial-to-parallel gather: collects up to NUM_INPUT words (or fewer, ended by
// s_last) into one zero-padded parallel group with a one-deep output register.
module multi_input_gather
    import multi_input_pkg::*;
#(
    parameter int NUM_INPUT = NUM_INPUT_DEF,
    parameter int WIDTH_IN  = WIDTH_IN_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WIDTH_IN-1:0]           s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WIDTH_IN-1:0]           m_data [NUM_INPUT],
    output logic [$clog2(NUM_INPUT+1)-1:0] m_count,
    output logic                          m_last
);

    localparam int CW = $clog2(NUM_INPUT + 1);
    localparam int IW = $clog2(NUM_INPUT);

    gather_state_e         state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [WIDTH_IN-1:0]   bank_q [NUM_INPUT];
    logic [WIDTH_IN-1:0]   bank_d [NUM_INPUT];
    logic [CW-1:0]         hold_count_q, hold_count_d;
    logic                  hold_last_q, hold_last_d;
    logic                  m_valid_q, m_valid_d;
    logic [WIDTH_IN-1:0]   m_data_q [NUM_INPUT];
    logic [WIDTH_IN-1:0]   m_data_d [NUM_INPUT];
    logic [CW-1:0]         m_count_q, m_count_d;
    logic                  m_last_q, m_last_d;

    logic                  s_ready_s;
    logic                  accept_s;
    logic                  out_free_s;
    logic                  complete_s;
    logic [CW-1:0]         idx_count_s;

    assign accept_s    = s_valid & s_ready_s;
    assign out_free_s  = ~m_valid_q | m_ready;
    assign complete_s  = accept_s & ((idx_q == IW'(NUM_INPUT - 1)) | s_last);
    assign idx_count_s = CW'(idx_q) + {{(CW-1){1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a completed group parks in FULL only while the output is occupied
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (complete_s && !out_free_s) begin
                    state_d = FULL;
                end else begin
                    state_d = COLLECT;
                end
            end
            FULL: begin
                if (out_free_s) begin
                    state_d = COLLECT;
                end else begin
                    state_d = FULL;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Output decode: upstream is only accepted while collecting
    always_comb begin
        s_ready_s = 1'b0;
        case (state_q)
            COLLECT: s_ready_s = 1'b1;
            FULL:    s_ready_s = 1'b0;
            default: s_ready_s = 1'b0;
        endcase
    end

    // Datapath next values: bank fill, hand-off to the output register, bank clear
    always_comb begin
        bank_d       = bank_q;
        idx_d        = idx_q;
        hold_count_d = hold_count_q;
        hold_last_d  = hold_last_q;
        m_valid_d    = m_valid_q & ~m_ready;
        m_data_d     = m_data_q;
        m_count_d    = m_count_q;
        m_last_d     = m_last_q;
        case (state_q)
            COLLECT: begin
                if (accept_s) begin
                    bank_d[idx_q] = s_data;
                    if (complete_s) begin
                        if (out_free_s) begin
                            m_valid_d = 1'b1;
                            m_data_d  = bank_d;
                            m_count_d = idx_count_s;
                            m_last_d  = s_last;
                            idx_d     = {IW{1'b0}};
                            for (int i = 0; i < NUM_INPUT; i++) begin
                                bank_d[i] = {WIDTH_IN{1'b0}};
                            end
                        end else begin
                            hold_count_d = idx_count_s;
                            hold_last_d  = s_last;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1'b1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            FULL: begin
                if (out_free_s) begin
                    m_valid_d = 1'b1;
                    m_data_d  = bank_q;
                    m_count_d = hold_count_q;
                    m_last_d  = hold_last_q;
                    idx_d     = {IW{1'b0}};
                    for (int i = 0; i < NUM_INPUT; i++) begin
                        bank_d[i] = {WIDTH_IN{1'b0}};
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: idx_d = {IW{1'b0}};
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= {IW{1'b0}};
            hold_count_q <= {CW{1'b0}};
            hold_last_q  <= 1'b0;
            m_valid_q    <= 1'b0;
            m_count_q    <= {CW{1'b0}};
            m_last_q     <= 1'b0;
            for (int i = 0; i < NUM_INPUT; i++) begin
                bank_q[i]   <= {WIDTH_IN{1'b0}};
                m_data_q[i] <= {WIDTH_IN{1'b0}};
            end
        end else begin
            idx_q        <= idx_d;
            hold_count_q <= hold_count_d;
            hold_last_q  <= hold_last_d;
            m_valid_q    <= m_valid_d;
            m_count_q    <= m_count_d;
            m_last_q     <= m_last_d;
            for (int i = 0; i < NUM_INPUT; i++) begin
                bank_q[i]   <= bank_d[i];
                m_data_q[i] <= m_data_d[i];
            end
        end
    end

    assign s_ready = s_ready_s;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_count = m_count_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_multi_input_gather.sv
// Scoreboard bench for multi_input_gather: a queue-based group model predicts each
// parallel group; a negedge monitor compares groups, hold stability and the group sum.
module tb_multi_input_gather;

    localparam int N  = 7;
    localparam int W  = 16;
    localparam int CW = 3;

    typedef struct packed {
        logic [N-1:0][W-1:0] w;
        logic [3:0]          cnt;
        logic                last;
    } grp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data [N];
    logic [CW-1:0] m_count;
    logic          m_last;

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    grp_t          expq[$];
    logic [W-1:0]  cur[$];
    int            pop_cyc[$];
    bit            done_036;

    multi_input_gather #(.NUM_INPUT(N), .WIDTH_IN(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_count(m_count), .m_last(m_last)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] flat_dut();
        logic [127:0] r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = m_data[i];
        return r;
    endfunction

    // Reference model: a group is whatever words were accepted until N words or s_last.
    grp_t mg;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            cur.delete();
            expq.delete();
        end else if (s_valid && s_ready) begin
            cur.push_back(s_data);
            if (cur.size() == N || s_last) begin
                mg = '0;
                for (int i = 0; i < cur.size(); i++) mg.w[i] = cur[i];
                mg.cnt  = 4'(cur.size());
                mg.last = s_last;
                expq.push_back(mg);
                cur.delete();
            end
        end
    end

    // Monitor: holds must stay stable; each consumed group is checked against the model.
    grp_t         g;
    bit           holding = 1'b0;
    logic [127:0] hold_data;
    logic [CW-1:0] hold_cnt;
    logic         hold_last;
    logic [W+2:0] dut_sum, exp_sum;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            if (holding) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", flat_dut(), hold_data);
                check("hold_count", m_count, hold_cnt);
                check("hold_last", m_last, hold_last);
            end
            if (m_valid && m_ready) begin
                pop_cyc.push_back(cyc);
                if (expq.size() == 0) begin
                    check("unexpected_group_valid", m_valid, 0);
                end else begin
                    g = expq.pop_front();
                    check("group_data", flat_dut(), g.w);
                    check("group_count", m_count, g.cnt);
                    check("group_last", m_last, g.last);
                    dut_sum = '0;
                    exp_sum = '0;
                    for (int i = 0; i < N; i++) dut_sum += (W+3)'(m_data[i]);
                    for (int i = 0; i < g.cnt; i++) exp_sum += (W+3)'(g.w[i]);
                    check("adder_sum", dut_sum, exp_sum);
                end
            end
            holding   = m_valid && !m_ready;
            hold_data = flat_dut();
            hold_cnt  = m_count;
            hold_last = m_last;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l, output int waits);
        waits   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        check("send_accept", s_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int n;
        logic [W-1:0] short_words [3];
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        done_036 = 1'b0;
        step(2);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_count", m_count, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", flat_dut(), 0);
        check("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);

        // Words 1..7, full group with one-cycle latency
        for (int k = 1; k <= 7; k++) begin
            send(W'(k), 1'b0, w);
            if (k == 6) check("full_not_early", m_valid, 0);
        end
        idle();
        check("full_valid_latency", m_valid, 1);
        check("full_count", m_count, 7);
        check("full_last", m_last, 0);
        step(2);

        // Short group terminated by s_last
        short_words[0] = 16'hFFFF;
        short_words[1] = 16'h8000;
        short_words[2] = 16'h0001;
        for (int k = 0; k < 3; k++) send(short_words[k], (k == 2), w);
        idle();
        check("short_valid", m_valid, 1);
        check("short_count", m_count, 3);
        check("short_last", m_last, 1);
        check("short_zero_slot", m_data[3], 0);
        step(2);

        // Group A held, group B backs up into FULL
        m_ready = 1'b0;
        for (int k = 0; k < 7; k++) send(W'($urandom), 1'b0, w);
        for (int k = 0; k < 7; k++) send(W'($urandom), 1'b0, w);
        idle();
        check("full_s_ready_low", s_ready, 0);
        check("full_a_held", m_valid, 1);
        step(3);
        check("full_still_low", s_ready, 0);
        m_ready = 1'b1;
        step(1);
        check("b_s_ready_back", s_ready, 1);
        check("b_valid", m_valid, 1);
        step(3);

        // 14 back-to-back words, s_ready never drops
        pop_cyc.delete();
        for (int k = 0; k < 14; k++) begin
            send(W'($urandom), 1'b0, w);
            check("b2b_no_stall", w, 0);
        end
        idle();
        step(3);
        check("b2b_group_cnt", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2) check("b2b_spacing", pop_cyc[1] - pop_cyc[0], 7);

        // Reset mid-group discards partial data
        for (int k = 0; k < 4; k++) send(W'($urandom), 1'b0, w);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_count", m_count, 0);
        check("midrst_m_last", m_last, 0);
        check("midrst_m_data", flat_dut(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        for (int k = 10; k <= 16; k++) send(W'(k), 1'b0, w);
        idle();
        check("postrst_valid", m_valid, 1);
        check("postrst_count", m_count, 7);
        step(2);

        // Random groups with random back-pressure; sums checked by the monitor
        fork
            begin
                for (int gi = 0; gi < 40; gi++) begin
                    int len;
                    len = $urandom_range(1, 7);
                    for (int k = 0; k < len; k++) begin
                        send(W'($urandom), (k == len - 1) && (len < 7 || $urandom_range(0, 1) == 1), w);
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        step($urandom_range(1, 3));
                    end
                end
                idle();
                done_036 = 1'b1;
            end
            begin
                while (!done_036) begin
                    m_ready = ($urandom_range(0, 1) == 1);
                    step(1);
                end
                m_ready = 1'b1;
            end
        join

        n = 0;
        while (expq.size() != 0 && n < 100) begin
            step(1);
            n++;
        end
        step(2);
        check("drain_empty", expq.size(), 0);
        check("no_partial", cur.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
